// File: rtl/clock_period_meter.sv
// Measures period and high time of a slow asynchronous square wave in iclk cycles,
// with a one-cycle valid strobe per completed period and a sticky timeout on a dead input.
module clock_period_meter #(
    parameter int          WIDTH          = 32,
    parameter int unsigned TIMEOUT_CYCLES = 50000000
) (
    input  logic             iclk,
    input  logic             reset,
    input  logic             sig_in,
    output logic [WIDTH-1:0] period,
    output logic [WIDTH-1:0] high_time,
    output logic             valid,
    output logic             locked,
    output logic             timeout
);
    localparam logic [WIDTH-1:0] CNT_MAX = WIDTH'(TIMEOUT_CYCLES - 1);

    typedef enum logic {IDLE, MEASURE} state_t;

    state_t           state;
    logic             s1, s2, s3;
    logic             rise, fall;
    logic [WIDTH-1:0] cnt, hi_cap, cnt_inc;

    // Both edges come from the same s2/s3 pair, so rise and fall share one latency.
    assign rise    = s2 & ~s3;
    assign fall    = ~s2 & s3;
    assign cnt_inc = cnt + WIDTH'(1);

    always_ff @(posedge iclk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            s1        <= 1'b0;
            s2        <= 1'b0;
            s3        <= 1'b0;
            cnt       <= '0;
            hi_cap    <= '0;
            period    <= '0;
            high_time <= '0;
            valid     <= 1'b0;
            locked    <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            s1    <= sig_in;
            s2    <= s1;
            s3    <= s2;
            valid <= 1'b0;

            if (rise)
                cnt <= '0;
            else if (cnt != CNT_MAX)
                cnt <= cnt_inc;

            case (state)
                IDLE: begin
                    if (rise) begin
                        state   <= MEASURE;
                        timeout <= 1'b0;
                        hi_cap  <= '0;
                    end
                end
                MEASURE: begin
                    if (rise) begin
                        period    <= cnt_inc;
                        // hi_cap is never 0 once a fall has been captured, so 0 means no fall seen.
                        high_time <= (hi_cap == '0) ? cnt_inc : hi_cap;
                        valid     <= 1'b1;
                        locked    <= 1'b1;
                        hi_cap    <= '0;
                    end else begin
                        if (fall)
                            hi_cap <= cnt_inc;
                        if (cnt == CNT_MAX) begin
                            state   <= IDLE;
                            timeout <= 1'b1;
                            locked  <= 1'b0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_clock_period_meter.sv
// Bench for clock_period_meter: directed runs plus random square waves, checked every
// cycle against an edge-timestamp reference model with a fixed two-cycle detection delay.
module tb_clock_period_meter;
    localparam int WIDTH = 32;
    localparam int T     = 100;

    logic             iclk, reset, sig_in;
    logic [WIDTH-1:0] period, high_time;
    logic             valid, locked, timeout;

    clock_period_meter #(.WIDTH(WIDTH), .TIMEOUT_CYCLES(T)) dut (
        .iclk(iclk), .reset(reset), .sig_in(sig_in),
        .period(period), .high_time(high_time),
        .valid(valid), .locked(locked), .timeout(timeout)
    );

    always #10 iclk = ~iclk;

    typedef struct {
        bit v;
        int p;
        int h;
        bit l;
        bit t;
    } exp_t;

    int   ncmp = 0;
    int   nerr = 0;
    int   n    = 0;
    exp_t cur;
    exp_t pipe [3];
    bit   prev, m_started, m_fell;
    int   m_a, m_f;
    int   seen_per, seen_hi, nvalid;
    bit   saw_to;

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        ncmp++;
        assert (got === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        cur       = '{0, 0, 0, 0, 0};
        for (int i = 0; i < 3; i++) pipe[i] = cur;
        prev      = 0;
        m_started = 0;
        m_fell    = 0;
        m_a       = 0;
        m_f       = 0;
    endtask

    // Reference works on timestamps of sampled edges: period = rise-to-rise distance,
    // high = rise-to-fall distance, timeout when T samples pass after a rise with no new rise.
    task automatic model_step(bit v);
        bit rose, fell;
        rose  = v && !prev;
        fell  = !v && prev;
        prev  = v;
        cur.v = 0;
        if (rose) begin
            if (m_started) begin
                cur.v = 1;
                cur.p = n - m_a;
                cur.h = m_fell ? (m_f - m_a) : (n - m_a);
                cur.l = 1;
            end
            cur.t     = 0;
            m_started = 1;
            m_a       = n;
            m_fell    = 0;
        end else begin
            if (fell && m_started) begin
                m_f    = n;
                m_fell = 1;
            end
            if (m_started && (n - m_a) == T) begin
                m_started = 0;
                cur.t     = 1;
                cur.l     = 0;
            end
        end
        pipe[2] = pipe[1];
        pipe[1] = pipe[0];
        pipe[0] = cur;
    endtask

    task automatic tick(bit v);
        @(negedge iclk);
        sig_in = v;
        @(posedge iclk);
        n++;
        model_step(v);
        #1;
        chk("valid", 32'(valid), 32'(pipe[2].v));
        chk("period", period, pipe[2].p);
        chk("high_time", high_time, pipe[2].h);
        chk("locked", 32'(locked), 32'(pipe[2].l));
        chk("timeout", 32'(timeout), 32'(pipe[2].t));
        if (valid) begin
            seen_per = period;
            seen_hi  = high_time;
            nvalid++;
        end
        if (timeout) saw_to = 1;
    endtask

    task automatic seg(bit v, int cycles);
        repeat (cycles) tick(v);
    endtask

    task automatic sq(int hi, int lo, int count);
        repeat (count) begin
            seg(1, hi);
            seg(0, lo);
        end
    endtask

    task automatic check_zero(string tag);
        chk({tag, "_period"}, period, 0);
        chk({tag, "_high"}, high_time, 0);
        chk({tag, "_valid"}, 32'(valid), 0);
        chk({tag, "_locked"}, 32'(locked), 0);
        chk({tag, "_timeout"}, 32'(timeout), 0);
    endtask

    // Called just after a checked posedge: asserts reset between edges.
    task automatic async_reset(string tag);
        #3;
        reset = 1;
        #1;
        check_zero(tag);
        model_reset();
        repeat (2) @(posedge iclk);
        #2;
        reset = 0;
    endtask

    initial begin
        iclk   = 0;
        reset  = 1;
        sig_in = 0;
        saw_to = 0;
        nvalid = 0;
        model_reset();
        #1;
        check_zero("por");
        repeat (2) @(posedge iclk);
        #2;
        reset = 0;

        // Run 1: 4/4 toggle
        sq(4, 4, 6);
        chk("r1_period", seen_per, 8);
        chk("r1_high", seen_hi, 4);
        chk("r1_locked", 32'(locked), 1);

        // Run 3: stuck low, then recovery
        seg(0, 120);
        chk("r3_timeout", 32'(timeout), 1);
        chk("r3_locked", 32'(locked), 0);
        chk("r3_period_held", period, 8);
        nvalid = 0;
        sq(4, 4, 1);
        chk("r3_cleared", 32'(timeout), 0);
        chk("r3_no_valid_first", nvalid, 0);
        sq(4, 4, 3);
        chk("r3_valid_back", 32'(nvalid > 0), 1);

        // Run 2: duty change
        sq(3, 7, 4);
        chk("r2a_period", seen_per, 10);
        chk("r2a_high", seen_hi, 3);
        sq(7, 3, 3);
        chk("r2b_period", seen_per, 10);
        chk("r2b_high", seen_hi, 7);

        // Run 4: rise exactly at the timeout boundary, then one cycle later
        sq(4, 4, 2);
        saw_to = 0;
        seg(1, 4);
        seg(0, 96);
        seg(1, 4);
        chk("r4_period100", seen_per, 100);
        chk("r4_no_timeout", 32'(saw_to), 0);
        nvalid = 0;
        seg(0, 97);
        seg(1, 4);
        seg(0, 4);
        chk("r4_timeout", 32'(saw_to), 1);
        chk("r4_no_valid", nvalid, 0);

        // Run 5: reset mid-high while locked
        sq(4, 4, 3);
        seg(1, 2);
        async_reset("r5");
        nvalid = 0;
        seg(1, 2);
        seg(0, 4);
        chk("r5_no_early_valid", nvalid, 0);
        sq(4, 4, 3);

        // Run 6: single-cycle glitch on an idle line, then a second pulse
        seg(0, 120);
        nvalid = 0;
        seg(1, 1);
        seg(0, 30);
        chk("r6_no_valid", nvalid, 0);
        seg(1, 1);
        seg(0, 4);
        chk("r6_period", seen_per, 31);
        chk("r6_high", seen_hi, 1);

        // Random square waves, some with gaps straddling the timeout
        for (int i = 0; i < 40; i++) begin
            int hi, lo;
            hi = $urandom_range(1, 20);
            lo = ($urandom_range(0, 5) == 0) ? $urandom_range(90, 104 - hi) : $urandom_range(1, 20);
            sq(hi, lo, $urandom_range(1, 4));
            if ($urandom_range(0, 9) == 0) seg(1, $urandom_range(95, 110));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule
